duty_step_ctrl: RTL and testbench

Debounced step controller for the DPWM 3-bit duty counter. Turns two raw push-button inputs into single-cycle increment/decrement strobes for the duty counter. Arbitrates simultaneous presses and keeps a shadow copy of the duty value so the strobes saturate at 0 and 7 instead of wrapping. Sits between the board buttons and the duty counter's `Aumentar`/`Disminuir` inputs, in the `clkm` domain.

---
 rtl/duty_step_ctrl_if.sv | 20 ++
 rtl/duty_step_ctrl.sv | 172 +++++++++++++++++
 tb/tb_duty_step_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/duty_step_ctrl_if.sv
// Button-in / strobe-out bundle between the board buttons, duty_step_ctrl
// and the DPWM duty counter's Aumentar/Disminuir inputs.
interface duty_step_ctrl_if;
    logic       btn_up;
    logic       btn_dn;
    logic       aumentar;
    logic       disminuir;
    logic [2:0] duty_shadow;
    logic       busy;

    modport master (
        output btn_up, btn_dn,
        input  aumentar, disminuir, duty_shadow, busy
    );

    modport slave (
        input  btn_up, btn_dn,
        output aumentar, disminuir, duty_shadow, busy
    );
endinterface

// File: rtl/duty_step_ctrl.sv
// Debounced, saturating up/down step controller for the DPWM 3-bit duty counter.
// Optional auto-repeat while a button is held: define DUTY_STEP_AUTOREPEAT_EN.
module duty_step_ctrl #(
    parameter int unsigned DEB_CYCLES = 50000,
    parameter int unsigned REP_DELAY  = 25000000,
    parameter int unsigned REP_PERIOD = 5000000
) (
    input  logic            clkm,
    input  logic            reset,
    duty_step_ctrl_if.slave bus
);

    if (DEB_CYCLES < 2 || DEB_CYCLES > 65535) begin : g_bad_deb
        $error("duty_step_ctrl: DEB_CYCLES must be within 2..65535");
    end
    if (REP_DELAY < 1 || REP_PERIOD < 1) begin : g_bad_rep
        $error("duty_step_ctrl: REP_DELAY and REP_PERIOD must be at least 1");
    end

    localparam logic [15:0] DEB_SAT  = 16'(DEB_CYCLES);
    localparam logic [15:0] DEB_LAST = 16'(DEB_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        DEBOUNCE,
        STEP,
        HOLD,
        LOCKOUT,
        RELEASE
    } state_t;

    state_t      state, state_d;
    logic [1:0]  up_sync, dn_sync;
    logic [1:0]  pair, pair_q;
    logic [15:0] deb_cnt;
    logic        stable;
    logic        dir_up, dir_up_d;
    logic        aum_q, aum_d;
    logic        dis_q, dis_d;
    logic [2:0]  shadow_q, shadow_d;
    logic        busy_q;

    always_ff @(posedge clkm or posedge reset) begin
        if (reset) begin
            up_sync <= '0;
            dn_sync <= '0;
        end else begin
            up_sync <= {up_sync[0], bus.btn_up};
            dn_sync <= {dn_sync[0], bus.btn_dn};
        end
    end

    assign pair = {up_sync[1], dn_sync[1]};

    // One counter serves both buttons: any change of the pair restarts it.
    always_ff @(posedge clkm or posedge reset) begin
        if (reset) begin
            pair_q  <= '0;
            deb_cnt <= '0;
        end else begin
            pair_q <= pair;
            if (pair != pair_q)
                deb_cnt <= '0;
            else if (deb_cnt != DEB_SAT)
                deb_cnt <= deb_cnt + 16'd1;
        end
    end

    assign stable = (deb_cnt == DEB_LAST) && (pair == pair_q);

`ifdef DUTY_STEP_AUTOREPEAT_EN
    localparam logic [31:0] REP_FIRST = 32'(REP_DELAY - 1);
    localparam logic [31:0] REP_NEXT  = 32'(REP_PERIOD - 1);

    logic [31:0] rep_cnt;
    logic        rep_armed;
    logic        rep_hit;

    assign rep_hit = (pair == pair_q) && (rep_cnt == (rep_armed ? REP_NEXT : REP_FIRST));

    // Counts from each STEP entry, so STEP-to-STEP spacing is exactly the delay/period.
    always_ff @(posedge clkm or posedge reset) begin
        if (reset) begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end else if (state_d == STEP) begin
            rep_cnt   <= '0;
            rep_armed <= (state == HOLD);
        end else if ((state == STEP || state == HOLD) && pair == pair_q) begin
            rep_cnt <= rep_cnt + 32'd1;
        end else begin
            rep_cnt   <= '0;
            rep_armed <= 1'b0;
        end
    end
`endif

    always_comb begin
        state_d  = state;
        dir_up_d = dir_up;
        aum_d    = 1'b0;
        dis_d    = 1'b0;
        shadow_d = shadow_q;
        case (state)
            IDLE: begin
                if (pair != 2'b00)
                    state_d = DEBOUNCE;
            end
            DEBOUNCE: begin
                if (pair == 2'b00)
                    state_d = IDLE;
                else if (stable) begin
                    if (pair == 2'b11)
                        state_d = LOCKOUT;
                    else begin
                        state_d  = STEP;
                        dir_up_d = pair[1];
                    end
                end
            end
            STEP: begin
                state_d = HOLD;
                if (dir_up && shadow_q != 3'd7) begin
                    aum_d    = 1'b1;
                    shadow_d = shadow_q + 3'd1;
                end else if (!dir_up && shadow_q != 3'd0) begin
                    dis_d    = 1'b1;
                    shadow_d = shadow_q - 3'd1;
                end
            end
            HOLD: begin
                if (pair == 2'b11)
                    state_d = LOCKOUT;
                else if (pair == 2'b00)
                    state_d = RELEASE;
`ifdef DUTY_STEP_AUTOREPEAT_EN
                else if (rep_hit)
                    state_d = STEP;
`endif
            end
            LOCKOUT, RELEASE: begin
                if (stable && pair == 2'b00)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clkm or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            dir_up   <= 1'b0;
            aum_q    <= 1'b0;
            dis_q    <= 1'b0;
            shadow_q <= '0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_d;
            dir_up   <= dir_up_d;
            aum_q    <= aum_d;
            dis_q    <= dis_d;
            shadow_q <= shadow_d;
            busy_q   <= (state_d != IDLE);
        end
    end

    assign bus.aumentar    = aum_q;
    assign bus.disminuir   = dis_q;
    assign bus.duty_shadow = shadow_q;
    assign bus.busy        = busy_q;

endmodule

// File: tb/tb_duty_step_ctrl.sv
// Directed bench for duty_step_ctrl (DEB_CYCLES=4, REP_DELAY=20, REP_PERIOD=8);
// expectations follow DUTY_STEP_AUTOREPEAT_EN when it is defined.
module tb_duty_step_ctrl;

`ifdef DUTY_STEP_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clkm = 1'b0;
    logic reset;
    duty_step_ctrl_if bus();

    duty_step_ctrl #(
        .DEB_CYCLES(4),
        .REP_DELAY (20),
        .REP_PERIOD(8)
    ) dut (
        .clkm (clkm),
        .reset(reset),
        .bus  (bus)
    );

    always #5 clkm = ~clkm;

    int unsigned cyc = 0;
    always @(posedge clkm) cyc <= cyc + 1;

    int n_up = 0;
    int n_dn = 0;
    int both_hi = 0;
    int long_pulse = 0;
    int unsigned last_up_cyc = 0;
    logic aum_prev = 1'b0;
    logic dis_prev = 1'b0;

    always @(negedge clkm) begin
        if (bus.aumentar === 1'b1) begin
            n_up = n_up + 1;
            last_up_cyc = cyc;
        end
        if (bus.disminuir === 1'b1) n_dn = n_dn + 1;
        if (bus.aumentar === 1'b1 && bus.disminuir === 1'b1) both_hi = both_hi + 1;
        if ((bus.aumentar === 1'b1 && aum_prev) || (bus.disminuir === 1'b1 && dis_prev))
            long_pulse = long_pulse + 1;
        aum_prev = (bus.aumentar === 1'b1);
        dis_prev = (bus.disminuir === 1'b1);
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic press(input logic up, input logic dn, input int hold, input int gap);
        bus.btn_up = up;
        bus.btn_dn = dn;
        repeat (hold) @(negedge clkm);
        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;
        repeat (gap) @(negedge clkm);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clkm);
        reset = 1'b0;
        repeat (3) @(negedge clkm);
    endtask

    int unsigned p;
    int base_up, base_dn;

    initial begin
        reset = 1'b1;
        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;
        @(negedge clkm);
        check("rst_aumentar", bus.aumentar, 0);
        check("rst_disminuir", bus.disminuir, 0);
        check("rst_shadow", bus.duty_shadow, 0);
        check("rst_busy", bus.busy, 0);
        reset = 1'b0;
        repeat (3) @(negedge clkm);

        // single long up press: strobe 7 cycles after the first edge
        base_up = n_up;
        p = cyc;
        bus.btn_up = 1'b1;
        repeat (7) @(negedge clkm);
        check("t1_no_early_strobe", bus.aumentar, 0);
        @(negedge clkm);
        check("t1_strobe_at_7", bus.aumentar, 1);
        check("t1_shadow_step", bus.duty_shadow, 1);
        repeat (22) @(negedge clkm);
        bus.btn_up = 1'b0;
        check("t1_strobe_count", n_up - base_up, AR ? 2 : 1);
        repeat (6) @(negedge clkm);
        check("t1_busy_before_idle", bus.busy, 1);
        @(negedge clkm);
        check("t1_busy_idle", bus.busy, 0);
        check("t1_shadow_final", bus.duty_shadow, AR ? 2 : 1);

        // bouncing down button never debounces
        do_reset();
        base_dn = n_dn;
        for (int i = 0; i < 10; i++) begin
            bus.btn_dn = ~bus.btn_dn;
            repeat (2) @(negedge clkm);
        end
        bus.btn_dn = 1'b0;
        repeat (10) @(negedge clkm);
        check("t2_no_disminuir", n_dn - base_dn, 0);
        check("t2_shadow", bus.duty_shadow, 0);
        check("t2_busy", bus.busy, 0);

        // saturation at 7, then one step down
        base_up = n_up;
        for (int i = 0; i < 7; i++) press(1'b1, 1'b0, 12, 12);
        check("t3_seven_strobes", n_up - base_up, 7);
        check("t3_shadow_7", bus.duty_shadow, 7);
        for (int i = 0; i < 2; i++) press(1'b1, 1'b0, 12, 12);
        check("t3_saturated_count", n_up - base_up, 7);
        check("t3_shadow_sat", bus.duty_shadow, 7);
        base_dn = n_dn;
        press(1'b0, 1'b1, 12, 12);
        check("t3_down_strobe", n_dn - base_dn, 1);
        check("t3_shadow_6", bus.duty_shadow, 6);

        // simultaneous press locks out
        base_up = n_up;
        base_dn = n_dn;
        bus.btn_up = 1'b1;
        bus.btn_dn = 1'b1;
        repeat (20) @(negedge clkm);
        check("t4_lockout_busy", bus.busy, 1);
        check("t4_no_up", n_up - base_up, 0);
        check("t4_no_dn", n_dn - base_dn, 0);
        bus.btn_up = 1'b0;
        bus.btn_dn = 1'b0;
        repeat (12) @(negedge clkm);
        check("t4_lockout_exit", bus.busy, 0);
        press(1'b1, 1'b0, 12, 12);
        check("t4_after_lockout_up", n_up - base_up, 1);
        check("t4_shadow_7", bus.duty_shadow, 7);

        // reset in the middle of a held press
        do_reset();
        check("t5_shadow_cleared", bus.duty_shadow, 0);
        p = cyc;
        bus.btn_up = 1'b1;
        repeat (8) @(negedge clkm);
        check("t5_first_strobe", bus.aumentar, 1);
        repeat (2) @(negedge clkm);
        reset = 1'b1;
        #1;
        check("t5_rst_shadow", bus.duty_shadow, 0);
        check("t5_rst_busy", bus.busy, 0);
        check("t5_rst_aumentar", bus.aumentar, 0);
        check("t5_rst_disminuir", bus.disminuir, 0);
        @(negedge clkm);
        reset = 1'b0;
        base_up = n_up;
        repeat (7) @(negedge clkm);
        check("t5_no_early_strobe", bus.aumentar, 0);
        @(negedge clkm);
        check("t5_fresh_strobe", bus.aumentar, 1);
        check("t5_fresh_shadow", bus.duty_shadow, 1);
        repeat (4) @(negedge clkm);
        bus.btn_up = 1'b0;
        repeat (12) @(negedge clkm);
        check("t5_single_strobe", n_up - base_up, 1);
        check("t5_busy_idle", bus.busy, 0);

        // re-press during RELEASE is merged into the first press
        base_up = n_up;
        press(1'b1, 1'b0, 12, 2);
        press(1'b1, 1'b0, 12, 12);
        check("t6_merged_press", n_up - base_up, 1);
        check("t6_shadow", bus.duty_shadow, 2);
        check("t6_busy_idle", bus.busy, 0);

        // 60-cycle hold from 0
        do_reset();
        base_up = n_up;
        p = cyc;
        bus.btn_up = 1'b1;
        repeat (60) @(negedge clkm);
        bus.btn_up = 1'b0;
        repeat (12) @(negedge clkm);
        check("t7_hold_count", n_up - base_up, AR ? 6 : 1);
        check("t7_hold_shadow", bus.duty_shadow, AR ? 6 : 1);
        check("t7_last_strobe_cycle", last_up_cyc - p - 1, AR ? 59 : 7);

        check("never_both_strobes", both_hi, 0);
        check("strobes_one_cycle", long_pulse, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
